seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 110 +++++++++++
 tb/tb_seg7_scan_driver.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with a shadow register and registered pin outputs.
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    hex_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [6:0]              seg_r, seg_n;
  logic [NUM_DIGITS-1:0]   dig_r, dig_n;
  logic [3:0]              code;
  logic                    blank;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic                    zero_above;
`endif

  function automatic logic [6:0] decode(input logic [3:0] c, input logic hex);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = hex ? 7'h77 : 7'h00;
      4'hB: s = hex ? 7'h1F : 7'h00;
      4'hC: s = hex ? 7'h4E : 7'h00;
      4'hD: s = hex ? 7'h3D : 7'h00;
      4'hE: s = hex ? 7'h4F : 7'h00;
      default: s = hex ? 7'h47 : 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    code  = '0;
    blank = 1'b0;
    dig_n = '0;
    seg_n = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) == idx) begin
        code     = shadow[4*k +: 4];
        blank    = blank_mask[k];
        dig_n[k] = 1'b1;
      end
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; digit 0 is never reached, so it is never suppressed.
    zero_above = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (shadow[4*k +: 4] == 4'h0);
      if ((IW'(k) == idx) && zero_above)
        blank = 1'b1;
    end
`endif
    if (cnt == '0) begin
      dig_n = '0;
      seg_n = '0;
    end else begin
      seg_n = blank ? 7'h00 : decode(code, hex_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      seg_r  <= '0;
      dig_r  <= '0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load)
        shadow <= digits;
      seg_r <= seg_n;
      dig_r <= dig_n;
    end
  end

  assign seg     = SEG_ACTIVE_LOW ? ~seg_r : seg_r;
  assign dig_sel = SEG_ACTIVE_LOW ? ~dig_r : dig_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver: three configurations checked against a cycle-count model.
// Honors SEG7_LEADING_ZERO_BLANK_EN in the model when the macro is defined.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = '0;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic        hex_en = 1'b0;

  logic [6:0] seg4, seg_al, seg1;
  logic [3:0] dig4, dig_al;
  logic [0:0] dig1;

  int checks = 0;
  int failures = 0;
  int e = 0;
  logic [3:0] sh [8];
  logic [6:0] es4, es1;
  logic [7:0] ed4, ed1;

  localparam logic [6:0] TBL [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                     7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .load(load), .blank_mask(blank_mask),
    .hex_en(hex_en), .seg(seg4), .dig_sel(dig4));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .digits(digits), .load(load), .blank_mask(blank_mask),
    .hex_en(hex_en), .seg(seg_al), .dig_sel(dig_al));

  seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .digits(digits[3:0]), .load(load), .blank_mask(blank_mask[0:0]),
    .hex_en(hex_en), .seg(seg1), .dig_sel(dig1));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h (edge %0d, t=%0t)", tag, got, exp, e, $time);
    end
  endtask

  // Expected registered output after edge number ev since reset release.
  function automatic void model(input int ev, input int n, input int sd,
                                output logic [6:0] s, output logic [7:0] d);
    int c, i;
    logic blk, allz;
    s = '0;
    d = '0;
    if (ev == 0) return;
    c = (ev - 1) % sd;
    i = ((ev - 1) / sd) % n;
    if (c == 0) return;
    d[i] = 1'b1;
    blk = blank_mask[i];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (i > 0) begin
      allz = 1'b1;
      for (int j = i; j < n; j++) if (sh[j] != 4'h0) allz = 1'b0;
      if (allz) blk = 1'b1;
    end
`else
    allz = 1'b0;
`endif
    if (blk || (sh[i] >= 4'd10 && !hex_en)) s = '0;
    else s = TBL[sh[i]];
  endfunction

  task automatic check_pins();
    check("seg", {1'b0, seg4}, {1'b0, es4});
    check("dig_sel", ed4, {4'b0, dig4} == ed4 ? ed4 : {4'b0, dig4});
    check("dig_sel4", {4'b0, dig4}, ed4);
    check("al_seg", {1'b0, seg_al}, {1'b0, ~es4});
    check("al_dig_sel", {4'b0, dig_al}, {4'b0, ~ed4[3:0]});
    check("n1_seg", {1'b0, seg1}, {1'b0, es1});
    check("n1_dig_sel", {7'b0, dig1}, ed1);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) e++;
    model(e, 4, 4, es4, ed4);
    model(e, 1, 3, es1, ed1);
    if (rst_n && load)
      for (int k = 0; k < 4; k++) sh[k] = digits[4*k +: 4];
    #1;
    check_pins();
  endtask

  task automatic do_load(input logic [15:0] v);
    digits = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    logic [15:0] r;
    for (int k = 0; k < 8; k++) sh[k] = '0;
    #1;
    es4 = '0; ed4 = '0; es1 = '0; ed1 = '0;
    check_pins();
    run(2);
    @(negedge clk);
    rst_n = 1'b1;

    do_load(16'h4321);
    run(20);

    hex_en = 1'b1;
    do_load(16'hFA90);
    run(16);
    hex_en = 1'b0;
    run(16);

    do_load(16'h8888);
    blank_mask = 4'b0100;
    run(16);
    blank_mask = 4'b0000;

    do_load(16'h0070);
    run(16);
    do_load(16'h0000);
    run(16);

    // Restart the edge count so the reset lands mid-slot at digit 2.
    do_load(16'h5678);
    while (e % 16 != 10) step();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) sh[k] = '0;
    e = 0;
    es4 = '0; ed4 = '0; es1 = '0; ed1 = '0;
    check_pins();
    run(2);
    @(negedge clk);
    rst_n = 1'b1;
    run(8);

    do_load(16'h0001);
    run(16);

    for (int it = 0; it < 400; it++) begin
      for (int k = 0; k < 4; k++)
        r[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      digits = r;
      load = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) blank_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) hex_en = ~hex_en;
      step();
      load = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
